// File: rtl/inv_key_schedule_if.sv
// Command and round-key stream bundle for inv_key_schedule.
// The master side starts schedules and consumes keys; the slave side is the key generator.
interface inv_key_schedule_if #(
  parameter int NK = 4
);
  logic             start;
  logic [0:32*NK-1] Key;
  logic             busy;
  logic [0:127]     rk;
  logic [3:0]       rk_round;
  logic             rk_last;
  logic             rk_valid;
  logic             rk_ready;
  logic             done;

  modport master (
    output start, Key, rk_ready,
    input  busy, rk, rk_round, rk_last, rk_valid, done
  );

  modport slave (
    input  start, Key, rk_ready,
    output busy, rk, rk_round, rk_last, rk_valid, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES inverse-cipher round-key generator: expands forward to the last round key, then walks
// the schedule backward through an NK-word window, streaming round keys Nr down to 0.
module inv_key_schedule #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  inv_key_schedule_if.slave bus
);
  localparam int         NR       = NK + 6;
  localparam int         W        = 4 * (NR + 1);
  localparam logic [5:0] NK6      = 6'(NK);
  localparam logic [5:0] FWD_LAST = 6'(W - NK - 1);

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, FWD, EMIT, STEP} state_t;

  state_t      state, state_nxt;
  logic [31:0] win     [NK];
  logic [31:0] win_nxt [NK];
  logic [5:0]  base, base_nxt;
  logic [3:0]  rnd, rnd_nxt;
  logic        done_q, done_nxt;

  logic        fwd;
  logic [5:0]  idx, phase, ofs;
  logic [3:0]  rc_idx;
  logic [31:0] x, sub_in, sub_out, tmp, new_word;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One temp() evaluation serves both directions: forward uses w[i-1] at the window top,
  // backward uses it one slot below, with i = b+NK or b+NK-1 respectively.
  always_comb begin
    fwd     = (state == FWD);
    idx     = fwd ? base + NK6 : base + NK6 - 6'd1;
    phase   = idx % NK6;
    rc_idx  = 4'(idx / NK6);
    x       = fwd ? win[NK-1] : win[NK-2];
    sub_in  = (phase == 6'd0) ? {x[23:0], x[31:24]} : x;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (phase == 6'd0)                 tmp = sub_out ^ {rcon(rc_idx), 24'h000000};
    else if (NK == 8 && phase == 6'd4) tmp = sub_out;
    else                               tmp = x;
    new_word = (fwd ? win[0] : win[NK-1]) ^ tmp;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    base_nxt  = base;
    rnd_nxt   = rnd;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          for (int j = 0; j < NK; j++) win_nxt[j] = bus.Key[32*j +: 32];
          base_nxt  = '0;
          state_nxt = FWD;
        end
      end
      FWD: begin
        for (int j = 0; j < NK - 1; j++) win_nxt[j] = win[j+1];
        win_nxt[NK-1] = new_word;
        base_nxt      = base + 6'd1;
        if (base == FWD_LAST) begin
          state_nxt = EMIT;
          rnd_nxt   = 4'(NR);
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          if (rnd == 4'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            rnd_nxt = rnd - 4'd1;
            // Rounds already covered by the window need no backward steps.
            if (base > {rnd - 4'd1, 2'b00}) state_nxt = STEP;
          end
        end
      end
      STEP: begin
        win_nxt[0] = new_word;
        for (int j = 1; j < NK; j++) win_nxt[j] = win[j-1];
        base_nxt = base - 6'd1;
        if (base - 6'd1 == {rnd, 2'b00}) state_nxt = EMIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      base   <= '0;
      rnd    <= '0;
      done_q <= 1'b0;
      // NOTE: the window array is cleared on reset so no key material survives an aborted run.
      for (int j = 0; j < NK; j++) win[j] <= '0;
    end else begin
      state  <= state_nxt;
      win    <= win_nxt;
      base   <= base_nxt;
      rnd    <= rnd_nxt;
      done_q <= done_nxt;
    end
  end

  // Round key sits at window offset 4r-b, which stays within 0..NK-4 while emitting.
  always_comb begin
    ofs    = {rnd, 2'b00} - base;
    bus.rk = '0;
    if (state == EMIT) begin
      for (int j = 0; j <= NK - 4; j++) begin
        if (ofs == 6'(j)) bus.rk = {win[j], win[j+1], win[j+2], win[j+3]};
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.rk_valid = (state == EMIT);
  assign bus.rk_round = (state == EMIT) ? rnd : 4'd0;
  assign bus.rk_last  = (state == EMIT) && (rnd == 4'd0);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule at NK = 4, 6 and 8, compared against a
// straightforward FIPS-197 key expansion with an arithmetic S-box.
module tb_inv_key_schedule;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start_v, ready_v;
  logic [255:0] key_v;
  int           sel;
  int           checks = 0;
  int           errors = 0;

  logic [127:0] o_rk;
  logic [3:0]   o_round;
  logic         o_last, o_valid, o_busy, o_done;

  logic [31:0]  mw [60];
  logic [127:0] exp_rk [15];

  localparam logic [255:0] KEY4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  inv_key_schedule_if #(.NK(4)) bus4 ();
  inv_key_schedule_if #(.NK(6)) bus6 ();
  inv_key_schedule_if #(.NK(8)) bus8 ();

  assign bus4.start = start_v[0];  assign bus4.rk_ready = ready_v[0];  assign bus4.Key = key_v[255:128];
  assign bus6.start = start_v[1];  assign bus6.rk_ready = ready_v[1];  assign bus6.Key = key_v[255:64];
  assign bus8.start = start_v[2];  assign bus8.rk_ready = ready_v[2];  assign bus8.Key = key_v;

  inv_key_schedule #(.NK(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  inv_key_schedule #(.NK(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));
  inv_key_schedule #(.NK(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  always_comb begin
    case (sel)
      1: begin o_rk = bus6.rk; o_round = bus6.rk_round; o_last = bus6.rk_last;
               o_valid = bus6.rk_valid; o_busy = bus6.busy; o_done = bus6.done; end
      2: begin o_rk = bus8.rk; o_round = bus8.rk_round; o_last = bus8.rk_last;
               o_valid = bus8.rk_valid; o_busy = bus8.busy; o_done = bus8.done; end
      default: begin o_rk = bus4.rk; o_round = bus4.rk_round; o_last = bus4.rk_last;
               o_valid = bus4.rk_valid; o_busy = bus4.busy; o_done = bus4.done; end
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Multiplicative inverse as a^254, followed by the affine transform.
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = a;
    for (int e = 0; e < 8; e++) begin
      if (e != 0) inv = gmul(inv, sq);
      sq = gmul(sq, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
  endfunction

  task automatic build_model(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < nk; j++) mw[j] = key[255 - 32*j -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int n = 1; n < i / nk; n++) rc = xtime(rc);
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) exp_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  // Window base while emitting round r: the forward end point, or 4r once stepping has begun.
  function automatic int emit_base(input int nk, input int r);
    int top;
    top = 4 * (nk + 7) - nk;
    return (4 * r < top) ? 4 * r : top;
  endfunction

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < 8; i++) k = {k[223:0], 32'($urandom())};
    return k;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 128'(o_valid), 128'd0);
    check({tag, "_busy"},  128'(o_busy),  128'd0);
    check({tag, "_done"},  128'(o_done),  128'd0);
    check({tag, "_rk"},    o_rk,          128'd0);
    check({tag, "_round"}, 128'(o_round), 128'd0);
    check({tag, "_last"},  128'(o_last),  128'd0);
  endtask

  task automatic do_start(input logic [255:0] key);
    key_v   = key;
    start_v = 3'(1 << sel);
    @(posedge clk); #1;
    start_v = '0;
    check("busy_after_start", 128'(o_busy), 128'd1);
  endtask

  // Entered one step after the start edge; leaves in the done cycle (or right after a reset).
  task automatic collect(input int nk, input int stall_max, input int rst_round,
                         input bit poke, input bit use_spec, input logic [127:0] spec_first);
    int nr, cnt, gap, k;
    nr  = nk + 6;
    cnt = 1;
    while (!o_valid && cnt < 200) begin
      start_v = (poke && cnt == 5) ? 3'(1 << sel) : 3'b000;
      if (poke && cnt == 5) key_v = rnd_key();
      @(posedge clk); #1;
      cnt++;
    end
    start_v = '0;
    check("first_valid_edges", 128'(cnt), 128'(4 * (nr + 1) - nk + 1));
    for (int r = nr; r >= 0; r--) begin
      gap = 0;
      while (!o_valid && gap < 20) begin
        @(posedge clk); #1;
        gap++;
      end
      if (r < nr)
        check($sformatf("step_gap_r%0d", r), 128'(gap), 128'(emit_base(nk, r + 1) - emit_base(nk, r)));
      check($sformatf("rk_nk%0d_r%0d", nk, r), o_rk, exp_rk[r]);
      check($sformatf("round_r%0d", r), 128'(o_round), 128'(r));
      check($sformatf("last_r%0d", r), 128'(o_last), 128'(r == 0));
      if (use_spec && r == nr) check("spec_first_rk", o_rk, spec_first);
      if (r == rst_round) begin
        ready_v = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_v = '1;
        check_idle("rst_in_emit");
        return;
      end
      if (stall_max > 0) begin
        k = $urandom_range(stall_max, 0);
        ready_v = '0;
        repeat (k) begin
          @(posedge clk); #1;
          check("stall_valid", 128'(o_valid), 128'd1);
          check("stall_rk", o_rk, exp_rk[r]);
          check("stall_round", 128'(o_round), 128'(r));
        end
        ready_v = '1;
      end
      @(posedge clk); #1;
    end
    check("done_pulse", 128'(o_done), 128'd1);
    check("busy_fall", 128'(o_busy), 128'd0);
    check("valid_after_last", 128'(o_valid), 128'd0);
  endtask

  task automatic run(input int nk, input logic [255:0] key, input int stall_max,
                     input bit use_spec, input logic [127:0] spec_first);
    sel = (nk - 4) / 2;
    build_model(nk, key);
    do_start(key);
    collect(nk, stall_max, -1, 1'b0, use_spec, spec_first);
    @(posedge clk); #1;
    check("done_one_cycle", 128'(o_done), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k;
    rst = 1'b1; start_v = '0; ready_v = '1; key_v = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle($sformatf("reset_nk%0d", 4 + 2 * s));
    end
    rst = 1'b0;

    // Known-answer vectors
    run(4, KEY4, 0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("nk4_r9_vector", exp_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    run(6, KEY6, 0, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
    run(8, KEY8, 0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);

    // Random keys with consumer stalls
    run(4, rnd_key(), 7, 1'b0, '0);
    run(4, rnd_key(), 7, 1'b0, '0);
    run(6, rnd_key(), 5, 1'b0, '0);
    run(8, rnd_key(), 5, 1'b0, '0);
    run(4, rnd_key(), 0, 1'b0, '0);

    // Reset during the forward expansion
    sel = 0;
    k = rnd_key();
    build_model(4, k);
    do_start(k);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("rst_in_fwd");
    @(posedge clk); #1;
    check_idle("idle_after_rst_fwd");
    run(4, KEY4, 0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset while stalled in EMIT at round 5
    sel = 0;
    k = rnd_key();
    build_model(4, k);
    do_start(k);
    collect(4, 0, 5, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    check_idle("idle_after_rst_emit");
    run(4, rnd_key(), 3, 1'b0, '0);

    // start/Key disturbed while busy, then a new start in the done cycle
    sel = 0;
    k = rnd_key();
    build_model(4, k);
    do_start(k);
    collect(4, 0, -1, 1'b1, 1'b0, '0);
    k = rnd_key();
    build_model(4, k);
    do_start(k);
    collect(4, 0, -1, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    check("done_one_cycle_restart", 128'(o_done), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Sequential AES round-key generator for the inverse cipher. It takes a 128/192/256-bit cipher key, runs the key schedule forward one word per cycle to reach the final round key, then walks the schedule backward, one word per cycle. It delivers round keys Nr down to 0 over a valid/ready stream. It is the decryption-side counterpart of the combinational forward `KeyExpansion`, and replaces a full expanded-word bus with a single NK-word window register.

## Interface
- `NK`, 4, key length in 32-bit words; legal values 4, 6, 8. Nr = NK+6. W = 4·(Nr+1) = 44/52/60.
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  sampled in IDLE only; latches `Key` and begins a schedule.
- `Key`  in  32·NK  cipher key, MSB-first (`[0:32*NK-1]`), word 0 in bits 0..31, same packing as `KeyExpansion`.
- `busy`  out  1  high from the edge that accepts `start` until the edge that returns to IDLE.
- `rk`  out  128  round key, `[0:127]`, word 4r in bits 0..31.
- `rk_round`  out  4  round index of `rk`, from Nr down to 0.
- `rk_last`  out  1  high with `rk_valid` when `rk_round` = 0.
- `rk_valid`  out  1  round key available.
- `rk_ready`  in  1  consumer accepts; a transfer happens on an edge with `rk_valid & rk_ready`.
- `done`  out  1  one-cycle pulse on the edge after the round-0 transfer.

## Operation
- Window register: NK words holding w[b..b+NK−1]; `b` is a base counter.
- temp(i, x):
  - i mod NK = 0 → SubWord(RotWord(x)) ^ {Rcon[i/NK],00,00,00}.
  - NK = 8 and i mod NK = 4 → SubWord(x).
  - Otherwise x.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- S-box: combinational, 4 instances, shared by the forward and backward paths.
- States: IDLE, FWD, EMIT, STEP.
- IDLE: all outputs 0. On `start` = 1, load window = `Key` and b = 0, then go to FWD.
- FWD:
  - Each cycle: i = b+NK, compute w[i] = w[b] ^ temp(i, w[i−1]), shift the window up by one word, b ← b+1.
  - After W−NK cycles, b = W−NK; go to EMIT with r = Nr.
- EMIT:
  - `rk_valid` = 1, `rk` = window words at offset 4r−b .. 4r−b+3, `rk_round` = r.
  - On transfer with r = 0: go to IDLE and pulse `done`.
  - On transfer with r > 0: r ← r−1. If b > 4(r−1), go to STEP; otherwise stay in EMIT.
- STEP:
  - Each cycle: i = b−1+NK, compute w[b−1] = w[i] ^ temp(i, w[i−1]), shift the window down by one word, b ← b−1.
  - When b = 4r, go to EMIT.
  - For NK = 6 and 8, some rounds need 0 or 2 steps instead of 4; the comparison b > 4r alone decides.
- `rk`, `rk_round` and `rk_last` are stable while `rk_valid` = 1 and `rk_ready` = 0. `rk_valid` never drops without a transfer.
- `start` while busy is ignored; `Key` changes while busy have no effect.
- `rst` = 1 in any state: after that edge, state = IDLE, all outputs 0, the window is cleared, and no partial stream resumes.

## Timing
- `start` is sampled on edge E0. `rk_valid` first goes high after edge E0 + W − NK + 1: 41 edges for NK = 4, 47 for NK = 6, 53 for NK = 8.
- With `rk_ready` held high, a stepped round gives 1 transfer cycle plus `steps` STEP cycles, where steps = b − 4(r−1).
- NK = 4: rounds 9..0 are each preceded by 4 STEP cycles, so transfers are spaced 5 cycles apart.
- `done` is high exactly the one cycle after the round-0 transfer edge; `busy` falls on the same edge. A new `start` is accepted in the cycle `done` is high.
- Outputs are fully registered: no combinational path from `rk_ready` or `start` to any output.

## Test plan
- NK=4, Key=2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → first `rk`=d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_round`=10 at edge 41. Next `rk`=ac7766f319fadc2128d12941575c006e with `rk_round`=9. Last `rk` = the key, with `rk_round`=0 and `rk_last`=1. Then `done` pulses.
- NK=6, Key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → round 12 `rk`=e98ba06f448c773c8ecc720401002202. Round 0 `rk`=8e73b0f7da0e6452c810f32b809079e5. 13 transfers total.
- NK=8, Key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → round 14 `rk`=fe4890d1e6188d0b046df344706c631e. Round 13 is emitted with zero STEP cycles. Round 0 `rk`=603deb1015ca71be2b73aef0857d7781.
- NK=4, random `rk_ready` stalls of 0–7 cycles → `rk` and `rk_round` stay stable during each stall. The sequence is identical to the no-stall run, and exactly 11 transfers occur.
- `rst` pulsed during FWD, and again while EMIT is stalled at round 5 → outputs 0 on the next cycle. A fresh `start` then yields the full correct sequence from round 10.
- `start` re-asserted while busy, and in the `done` cycle → the busy re-assert is ignored. The `done`-cycle `start` begins a new run whose first `rk_valid` arrives 41 edges later.
